// File: rtl/md_pkg.sv
// Shared constants for the MIPS multiply/divide sequencer: operation codes,
// FSM state encodings and the iteration count of the shift-add / restoring loop.
package md_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

endpackage

// File: rtl/md_addsub.sv
// Combinational (W+1)-bit add/subtract shared by every phase of the sequencer.
// Ports:
//   x_i, y_i  operands
//   sub_i     1: x - y, 0: x + y
//   sum_o     result, W+1 bits
//   cb_o      carry out for add, borrow (x < y) for subtract
module md_addsub #(
  parameter int W = 32
) (
  input  logic [W:0] x_i,
  input  logic [W:0] y_i,
  input  logic       sub_i,
  output logic [W:0] sum_o,
  output logic       cb_o
);

  logic [W+1:0] full;

  always_comb begin
    full = {1'b0, x_i} + {1'b0, (sub_i ? ~y_i : y_i)} + {{(W+1){1'b0}}, sub_i};
  end

  assign sum_o = full[W:0];
  // Subtract is x + ~y + 1: a carry out means no borrow.
  assign cb_o  = full[W+1] ^ sub_i;

endmodule

// File: rtl/mul_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// IDLE -> PREP (1) -> RUN (ITER) -> FIX (1) -> IDLE; done pulses after FIX.
// Ports:
//   clk_i, reset_i         clock, async active-high reset
//   start_i, op_i          launch request and operation (accepted only when idle)
//   a_i, b_i               rs / rt operands
//   hi_we_i, lo_we_i       MTHI / MTLO strobes (idle only), data on wdata_i
//   busy_o                 operation in flight
//   done_o, div_by_zero_o  one-cycle completion pulse, divide-by-zero flag
//   hi_o, lo_o             HI / LO registers
module mul_div_seq
  import md_pkg::*;
#(
  parameter int WIDTH = md_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [1:0]       state_q, state_d, op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, bmag_q, bmag_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic             sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic             done_q, done_d, dz_q, dz_d;

  logic [WIDTH:0]     au_x, au_y, au_sum;
  logic               au_sub, au_cb;
  logic [WIDTH-1:0]   a_mag;
  logic [2*WIDTH-1:0] prod, prod_neg;

  md_addsub #(.W(WIDTH)) u_addsub (
    .x_i   (au_x),
    .y_i   (au_y),
    .sub_i (au_sub),
    .sum_o (au_sum),
    .cb_o  (au_cb)
  );

  // One use of the shared unit per state: b magnitude while accepting the op,
  // a magnitude in PREP, iteration step in RUN, quotient negate in FIX.
  always_comb begin
    au_x   = '0;
    au_y   = '0;
    au_sub = 1'b1;
    unique case (state_q)
      S_IDLE: au_y = {1'b0, b_i};
      S_PREP: au_y = {1'b0, a_q};
      S_RUN: begin
        if (op_q[1]) begin
          au_x = {acc_hi_q, acc_lo_q[MSB]};
          au_y = {1'b0, mcand_q};
        end else begin
          au_x   = {1'b0, acc_hi_q};
          au_y   = acc_lo_q[0] ? {1'b0, mcand_q} : '0;
          au_sub = 1'b0;
        end
      end
      S_FIX:   au_y = {1'b0, acc_lo_q};
      default: au_y = '0;
    endcase
  end

  assign a_mag    = (op_q[0] && a_q[MSB]) ? au_sum[MSB:0] : a_q;
  assign prod     = {acc_hi_q, acc_lo_q};
  // Product negate gets its own incrementer so FIX stays a single cycle.
  assign prod_neg = ~prod + {{(2*WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    bmag_d   = bmag_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          state_d  = S_PREP;
          op_d     = op_i;
          a_d      = a_i;
          bmag_d   = (op_i[0] && b_i[MSB]) ? au_sum[MSB:0] : b_i;
          sign_q_d = op_i[0] & (a_i[MSB] ^ b_i[MSB]);
          sign_r_d = op_i[0] & a_i[MSB];
          cnt_d    = '0;
        end
      end
      S_PREP: begin
        acc_hi_d = '0;
        if (op_q[1]) begin
          acc_lo_d = a_mag;
          mcand_d  = bmag_q;
        end else begin
          acc_lo_d = bmag_q;
          mcand_d  = a_mag;
        end
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (op_q[1]) begin
          if (!au_cb) begin
            acc_hi_d = au_sum[MSB:0];
            acc_lo_d = {acc_lo_q[MSB-1:0], 1'b1};
          end else begin
            acc_hi_d = {acc_hi_q[MSB-1:0], acc_lo_q[MSB]};
            acc_lo_d = {acc_lo_q[MSB-1:0], 1'b0};
          end
        end else begin
          // Shift {carry, acc_hi, acc_lo} right; the add carry becomes the new MSB.
          acc_hi_d = au_sum[WIDTH:1];
          acc_lo_d = {au_sum[0], acc_lo_q[MSB:1]};
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (!op_q[1]) begin
          {hi_d, lo_d} = sign_q_q ? prod_neg : prod;
        end else if (mcand_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
          dz_d = 1'b1;
        end else begin
          lo_d = sign_q_q ? au_sum[MSB:0] : acc_lo_q;
          hi_d = sign_r_q ? (~acc_hi_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_hi_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      bmag_q   <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      bmag_q   <= bmag_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign div_by_zero_o = dz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
